shift_rotate_unit: RTL and testbench

Multi-cycle shift/rotate execution unit for the datapath ALU. It shifts or rotates a 32-bit operand one bit position per clock and captures the result into an output result register that the Z register path consumes. It serves SHR, SHRA, SHL, ROR and ROL. Its rotate-left results are bit-identical to the combinational left rotator for the same amount. It is used when the sequencer trades latency for area, and it reports completion with a start/busy/done handshake.

---
 rtl/shift_rotate_unit.sv | 106 ++++++++++
 tb/tb_shift_rotate_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: one bit position per clock, start/busy/done handshake.
// Serves SHR, SHRA, SHL, ROR and ROL; the result is held in z_out until the next completion.
module shift_rotate_unit #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] amt,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] z_out,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic [AMT_W-1:0]  cnt;
    logic [2:0]        opr;
    logic [DATA_W-1:0] next_acc;
    logic [AMT_W-1:0]  amt_eff;
    logic              op_illegal;

    // The modulo folds every amount bit into the expression; only the low AMT_W bits survive.
    assign amt_eff    = AMT_W'(amt % DATA_W);
    assign op_illegal = (op > OP_ROL);

    // NOTE: every path assigns next_acc (default first), so no latch is inferred.
    always_comb begin
        next_acc = acc;
        case (opr)
            OP_SHR:  next_acc = {1'b0, acc[DATA_W-1:1]};
            OP_SHRA: next_acc = {acc[DATA_W-1], acc[DATA_W-1:1]};
            OP_SHL:  next_acc = {acc[DATA_W-2:0], 1'b0};
            OP_ROR:  next_acc = {acc[0], acc[DATA_W-1:1]};
            OP_ROL:  next_acc = {acc[DATA_W-2:0], acc[DATA_W-1]};
            default: next_acc = acc;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            opr   <= OP_SHR;
            busy  <= 1'b0;
            done  <= 1'b0;
            z_out <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= a;
                        cnt  <= amt_eff;
                        opr  <= op;
                        busy <= 1'b1;
                        // Zero amount or illegal op completes without any RUN cycles.
                        if (op_illegal || amt_eff == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            z_out <= a;
                            err   <= op_illegal;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= next_acc;
                    cnt <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        z_out <= next_acc;
                        err   <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Scoreboard bench for shift_rotate_unit: a driver pushes expected results from a reference
// model, a monitor pops and compares them whenever done pulses.
module tb_shift_rotate_unit;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] amt;
    logic        busy;
    logic        done;
    logic [31:0] z_out;
    logic        err;

    typedef struct {
        logic [31:0] z;
        logic        e;
        int          done_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    shift_rotate_unit #(.DATA_W(32), .AMT_W(5)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .op    (op),
        .a     (a),
        .amt   (amt),
        .busy  (busy),
        .done  (done),
        .z_out (z_out),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: returns {err, z} from plain arithmetic on the amount modulo 32.
    function automatic logic [32:0] ref_model(input logic [2:0] o, input logic [31:0] av,
                                              input logic [31:0] amv);
        int          n;
        logic [63:0] w;
        logic [31:0] z;
        n = int'(amv % 32);
        w = {av, av};
        z = av;
        if (o > 3'd4) return {1'b1, av};
        case (o)
            3'd0: z = av >> n;
            3'd1: z = 32'($signed(av) >>> n);
            3'd2: z = av << n;
            3'd3: begin w = w >> n; z = w[31:0];  end
            default: begin w = w << n; z = w[63:32]; end
        endcase
        return {1'b0, z};
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] amv);
        if (o > 3'd4 || amv % 32 == 0) return 1;
        return int'(amv % 32) + 1;
    endfunction

    // Called at a negedge with the DUT idle; returns just after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] amv);
        logic [32:0] r;
        exp_t        e;
        start = 1'b1;
        op    = o;
        a     = av;
        amt   = amv;
        @(posedge clk);
        #1;
        r          = ref_model(o, av, amv);
        e.z        = r[31:0];
        e.e        = r[32];
        e.done_cyc = cyc + ref_latency(o, amv) - 1;
        q.push_back(e);
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        amt   = $urandom;
    endtask

    // Counts busy cycles until the unit is idle again; optionally pokes start at busy cycle 'poke'.
    task automatic wait_idle(input int exp_busy, input int poke);
        int n     = 0;
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            n++;
            guard++;
            if (n == poke) begin
                start = 1'b1;
                op    = 3'd0;
                a     = $urandom;
                amt   = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_timeout", 32'(guard >= 200), 32'd0);
        check("busy_cycles", 32'(n), 32'(exp_busy));
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] amv);
        issue(o, av, amv);
        wait_idle(ref_latency(o, amv), -1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (clr_n && done) begin
            if (q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("z_out", z_out, e.z);
                check("err", 32'(err), 32'(e.e));
                check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                check("busy_with_done", 32'(busy), 32'd1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr_n = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'h0;
        amt   = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_z", z_out, 32'h0);
        clr_n = 1'b1;
        @(negedge clk);

        run_op(3'd4, 32'h8000_0001, 32'd1);
        run_op(3'd3, 32'h1234_5678, 32'd4);
        run_op(3'd2, 32'h1234_5678, 32'd4);
        run_op(3'd1, 32'h8000_0000, 32'd31);
        run_op(3'd0, 32'h8000_0000, 32'd31);
        run_op(3'd4, 32'hDEAD_BEEF, 32'd32);
        run_op(3'd7, 32'hCAFE_0123, 32'd9);
        run_op(3'd5, 32'h0BAD_F00D, 32'd3);
        run_op(3'd4, 32'h0000_0001, 32'd33);
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFE0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] amv;
            amv = (i % 4 == 0) ? $urandom : 32'($urandom_range(0, 31));
            run_op(3'($urandom_range(0, 7)), $urandom, amv);
        end

        // A start pulsed during RUN must be ignored.
        issue(3'd4, 32'hCAFE_F00D, 32'd8);
        wait_idle(9, 3);

        // Asynchronous reset in the middle of a long operation.
        issue(3'd3, 32'h1357_9BDF, 32'd20);
        repeat (7) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_z", z_out, 32'h0);
        q.delete();
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        run_op(3'd4, 32'h0000_0001, 32'd1);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
